// File: rtl/conv_pkg.sv
// Shared types for the depthwise 3x3 convolution front end.
// Pixel, window and window-generator state definitions.
package conv_pkg;

    localparam int WIN_SIZE = 9;
    localparam int PIX_W    = 8;

    typedef logic [PIX_W-1:0] pix_t;
    typedef pix_t [WIN_SIZE-1:0] win_t;

    typedef enum logic [1:0] {
        WG_IDLE  = 2'd0,
        WG_RUN   = 2'd1,
        WG_DRAIN = 2'd2
    } wg_state_e;

endpackage

// File: rtl/line_buffer.sv
// One image row of pixel storage.
// Combinational read and synchronous write share one address.
module line_buffer
    import conv_pkg::*;
#(
    parameter int DEPTH = 224,
    parameter int AW    = $clog2(DEPTH + 1)
) (
    input  logic          clock,
    input  logic          write_en,
    input  logic [AW-1:0] addr,
    input  pix_t          write_data,
    output pix_t          read_data
);

    pix_t mem [DEPTH];

    assign read_data = mem[addr];

    // store the incoming pixel at the current column
    always_ff @(posedge clock) begin
        if (write_en) begin
            mem[addr] <= write_data;
        end
    end

endmodule

// File: rtl/conv3x3_window_generator.sv
// Streams a raster plane in and emits 3x3 windows, stride 1 or 2.
// Two line buffers hold the previous rows; a 3x3 shift array holds the window.
module conv3x3_window_generator
    import conv_pkg::*;
#(
    parameter int MAX_WIDTH = 224,
    parameter int COL_W     = $clog2(MAX_WIDTH + 1),
    parameter int ROW_W     = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [COL_W-1:0] cfg_width,
    input  logic [ROW_W-1:0] cfg_height,
    input  logic             cfg_stride2,
    input  pix_t             pixel_in,
    input  logic             pixel_valid,
    output logic             pixel_ready,
    output pix_t             window_out [WIN_SIZE],
    output logic             window_valid,
    input  logic             window_ready,
    output logic [ROW_W-1:0] window_row,
    output logic [COL_W-1:0] window_col,
    output logic             busy,
    output logic             frame_done,
    output logic             cfg_error
);

    wg_state_e        state;
    wg_state_e        state_nx;
    logic [COL_W-1:0] width_q;
    logic [ROW_W-1:0] height_q;
    logic             stride2_q;
    logic [COL_W-1:0] col_q;
    logic [ROW_W-1:0] row_q;
    pix_t             lb_a_rd;
    pix_t             lb_b_rd;
    logic             accept;
    logic             cfg_ok;
    logic             take_start;
    logic             col_end;
    logic             last_px;
    logic             emit;

    assign cfg_ok = (cfg_width >= COL_W'(3))
                 && (32'(cfg_width) <= MAX_WIDTH)
                 && (cfg_height >= ROW_W'(3));

    assign take_start = (state == WG_IDLE) && start;
    assign accept     = pixel_valid && pixel_ready;
    assign col_end    = (col_q == width_q - COL_W'(1));
    assign last_px    = col_end && (row_q == height_q - ROW_W'(1));

    // stride 2 keeps only even offsets from the first full window
    assign emit = accept
               && (row_q >= ROW_W'(2))
               && (col_q >= COL_W'(2))
               && (!stride2_q || (!row_q[0] && !col_q[0]));

    line_buffer #(.DEPTH(MAX_WIDTH), .AW(COL_W)) lb_a (
        .clock      (clock),
        .write_en   (accept),
        .addr       (col_q),
        .write_data (lb_b_rd),
        .read_data  (lb_a_rd)
    );

    line_buffer #(.DEPTH(MAX_WIDTH), .AW(COL_W)) lb_b (
        .clock      (clock),
        .write_en   (accept),
        .addr       (col_q),
        .write_data (pixel_in),
        .read_data  (lb_b_rd)
    );

    // state register
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= WG_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // frame sequencing
    always_comb begin
        state_nx = state;
        unique case (state)
            WG_IDLE:  if (start && cfg_ok) state_nx = WG_RUN;
            WG_RUN:   if (accept && last_px) state_nx = WG_DRAIN;
            WG_DRAIN: if (!window_valid || window_ready) state_nx = WG_IDLE;
            default:  state_nx = WG_IDLE;
        endcase
    end

    // handshake and status outputs decoded from state
    always_comb begin
        pixel_ready = 1'b0;
        busy        = 1'b0;
        frame_done  = 1'b0;
        unique case (state)
            WG_RUN: begin
                pixel_ready = !window_valid || window_ready;
                busy        = 1'b1;
            end
            WG_DRAIN: begin
                busy       = 1'b1;
                frame_done = !window_valid || window_ready;
            end
            default: ;
        endcase
    end

    // config latch and raster position counters
    always_ff @(posedge clock) begin
        if (reset) begin
            width_q   <= '0;
            height_q  <= '0;
            stride2_q <= 1'b0;
            col_q     <= '0;
            row_q     <= '0;
        end else if (take_start && cfg_ok) begin
            width_q   <= cfg_width;
            height_q  <= cfg_height;
            stride2_q <= cfg_stride2;
            col_q     <= '0;
            row_q     <= '0;
        end else if (accept) begin
            if (col_end) begin
                col_q <= '0;
                row_q <= row_q + ROW_W'(1);
            end else begin
                col_q <= col_q + COL_W'(1);
            end
        end
    end

    // rejected start reports one cycle later
    always_ff @(posedge clock) begin
        if (reset) begin
            cfg_error <= 1'b0;
        end else begin
            cfg_error <= take_start && !cfg_ok;
        end
    end

    // window shift array, valid flag and output coordinates
    always_ff @(posedge clock) begin
        if (reset) begin
            window_out   <= '{default: '0};
            window_valid <= 1'b0;
            window_row   <= '0;
            window_col   <= '0;
        end else if (accept) begin
            for (int i = 0; i < 3; i++) begin
                window_out[3*i]   <= window_out[3*i+1];
                window_out[3*i+1] <= window_out[3*i+2];
            end
            window_out[2] <= lb_a_rd;
            window_out[5] <= lb_b_rd;
            window_out[8] <= pixel_in;
            window_valid  <= emit;
            if (emit) begin
                window_row <= (row_q - ROW_W'(2)) >> stride2_q;
                window_col <= (col_q - COL_W'(2)) >> stride2_q;
            end
        end else if (window_ready) begin
            window_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_conv3x3_window_generator.sv
// Randomised bench for the 3x3 window generator.
// Expected windows come from slicing a stored image directly.
module tb_conv3x3_window_generator;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  cfg_width;
    logic [15:0] cfg_height;
    logic        cfg_stride2;
    logic [7:0]  pixel_in;
    logic        pixel_valid;
    logic        pixel_ready;
    logic [7:0]  window_out [9];
    logic        window_valid;
    logic        window_ready;
    logic [15:0] window_row;
    logic [7:0]  window_col;
    logic        busy;
    logic        frame_done;
    logic        cfg_error;

    typedef struct {
        logic [71:0] win;
        int          row;
        int          col;
    } exp_t;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  img [16][224];
    exp_t        exp_q [$];
    logic [71:0] first_win;
    logic [71:0] last_win;

    conv3x3_window_generator dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .cfg_width    (cfg_width),
        .cfg_height   (cfg_height),
        .cfg_stride2  (cfg_stride2),
        .pixel_in     (pixel_in),
        .pixel_valid  (pixel_valid),
        .pixel_ready  (pixel_ready),
        .window_out   (window_out),
        .window_valid (window_valid),
        .window_ready (window_ready),
        .window_row   (window_row),
        .window_col   (window_col),
        .busy         (busy),
        .frame_done   (frame_done),
        .cfg_error    (cfg_error)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [71:0] got,
                         input logic [71:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [71:0] dut_win();
        logic [71:0] v;
        for (int i = 0; i < 9; i++) v[71-8*i -: 8] = window_out[i];
        return v;
    endfunction

    task automatic fill(input int w, input int h, input bit rnd);
        for (int r = 0; r < h; r++)
            for (int c = 0; c < w; c++)
                img[r][c] = rnd ? 8'($urandom) : 8'(r * w + c);
    endtask

    task automatic build(input int w, input int h, input bit s2);
        int   st;
        exp_t e;
        st = s2 ? 2 : 1;
        exp_q.delete();
        for (int tr = 0; tr + 2 < h; tr += st) begin
            for (int tc = 0; tc + 2 < w; tc += st) begin
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        e.win[71-8*(3*i+j) -: 8] = img[tr+i][tc+j];
                e.row = tr / st;
                e.col = tc / st;
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic run_frame(input int w, input int h, input bit s2,
                             input bit vrand, input bit rrand,
                             input int hold);
        int          n_exp;
        int          got;
        int          pi;
        int          cyc;
        int          rr;
        int          cc;
        int          hold_left;
        int          hold_row;
        int          hold_col;
        bit          done;
        bit          prev_acc;
        bit          want_wv;
        bit          prev_hold;
        logic [71:0] hold_win;
        exp_t        e;
        got = 0; pi = 0; cyc = 0; done = 0;
        prev_acc = 0; want_wv = 0; prev_hold = 0;
        hold_left = hold; hold_win = '0; hold_row = 0; hold_col = 0;
        build(w, h, s2);
        n_exp = exp_q.size();
        @(negedge clock);
        check("idle_before_start", busy, 0);
        start = 1'b1;
        cfg_width = 8'(w);
        cfg_height = 16'(h);
        cfg_stride2 = s2;
        @(negedge clock);
        start = 1'b0;
        check("busy_after_start", busy, 1);
        while (!done && cyc < w * h * 10 + 200) begin
            @(negedge clock);
            cyc++;
            if (prev_acc) check("latency", window_valid, want_wv);
            if (prev_hold) begin
                check("hold_valid", window_valid, 1);
                check("hold_win", dut_win(), hold_win);
                check("hold_row", window_row, hold_row);
                check("hold_col", window_col, hold_col);
            end
            pixel_valid = (pi < w * h) && (!vrand || $urandom_range(3) != 0);
            pixel_in = (pi < w * h) ? img[pi / w][pi % w] : 8'h00;
            if (window_valid && hold_left > 0) begin
                window_ready = 1'b0;
                hold_left--;
            end else begin
                window_ready = rrand ? 1'($urandom_range(1)) : 1'b1;
            end
            #1;
            prev_hold = window_valid && !window_ready;
            if (prev_hold) begin
                hold_win = dut_win();
                hold_row = int'(window_row);
                hold_col = int'(window_col);
                check("stall_pixel_ready", pixel_ready, 0);
            end
            if (window_valid && window_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_window", got + 1, n_exp);
                end else begin
                    e = exp_q.pop_front();
                    check("win", dut_win(), e.win);
                    check("win_row", window_row, e.row);
                    check("win_col", window_col, e.col);
                    if (got == 0) first_win = dut_win();
                    last_win = dut_win();
                    got++;
                end
            end
            if (frame_done) begin
                check("done_after_all", exp_q.size(), 0);
                done = 1;
            end
            prev_acc = pixel_valid && pixel_ready;
            if (prev_acc) begin
                rr = pi / w;
                cc = pi % w;
                want_wv = rr >= 2 && cc >= 2
                       && (!s2 || (rr % 2 == 0 && cc % 2 == 0));
                pi++;
            end
        end
        pixel_valid = 1'b0;
        check("frame_done_seen", done, 1);
        check("window_count", got, n_exp);
        check("pixel_count", pi, w * h);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_pixel_ready"}, pixel_ready, 0);
        check({tag, "_window_valid"}, window_valid, 0);
        check({tag, "_window_out"}, dut_win(), 0);
        check({tag, "_window_row"}, window_row, 0);
        check({tag, "_window_col"}, window_col, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_frame_done"}, frame_done, 0);
        check({tag, "_cfg_error"}, cfg_error, 0);
    endtask

    task automatic bad_start(input int w, input int h);
        @(negedge clock);
        start = 1'b1;
        cfg_width = 8'(w);
        cfg_height = 16'(h);
        cfg_stride2 = 1'b0;
        pixel_valid = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check("cfg_error_pulse", cfg_error, 1);
        check("cfg_error_busy", busy, 0);
        check("cfg_error_ready", pixel_ready, 0);
        @(negedge clock);
        check("cfg_error_clear", cfg_error, 0);
        check("cfg_error_idle", busy, 0);
        pixel_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        cfg_width = 8'd4;
        cfg_height = 16'd4;
        cfg_stride2 = 1'b0;
        pixel_in = 8'h00;
        pixel_valid = 1'b0;
        window_ready = 1'b0;
        first_win = '0;
        last_win = '0;
        repeat (3) @(negedge clock);
        check_reset_outputs("reset");
        reset = 1'b0;

        fill(4, 4, 0);
        run_frame(4, 4, 0, 0, 0, 0);
        check("s1_first_win", first_win, 72'h000102_040506_08090a);
        check("s1_last_win", last_win, 72'h050607_090a0b_0d0e0f);

        fill(5, 5, 0);
        run_frame(5, 5, 1, 0, 0, 0);
        check("s2_last_win", last_win, 72'h0c0d0e_111213_161718);

        fill(4, 4, 0);
        run_frame(4, 4, 0, 0, 0, 5);

        bad_start(2, 4);
        bad_start(225, 4);
        bad_start(4, 2);

        fill(4, 4, 0);
        @(negedge clock);
        start = 1'b1;
        cfg_width = 8'd4;
        cfg_height = 16'd4;
        cfg_stride2 = 1'b0;
        @(negedge clock);
        start = 1'b0;
        window_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            pixel_valid = 1'b1;
            pixel_in = img[i / 4][i % 4];
            @(negedge clock);
        end
        pixel_valid = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        check_reset_outputs("mid_reset");
        reset = 1'b0;
        run_frame(4, 4, 0, 0, 0, 0);

        fill(3, 3, 1);
        run_frame(3, 3, 0, 0, 0, 0);
        fill(3, 3, 1);
        run_frame(3, 3, 0, 0, 0, 0);

        fill(224, 3, 1);
        run_frame(224, 3, 0, 1, 1, 0);

        for (int k = 0; k < 8; k++) begin
            int w;
            int h;
            w = $urandom_range(12, 3);
            h = $urandom_range(10, 3);
            fill(w, h, 1);
            run_frame(w, h, 1'($urandom_range(1)), 1, 1,
                      $urandom_range(3));
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/conv3x3_window_generator.md
# conv3x3_window_generator

Streaming 3×3 window producer that feeds the depthwise 3×3 convolution engine. It accepts one 8-bit channel plane in raster order over a ready/valid stream and buffers two previous rows in line buffers. For every valid output position it emits a 3×3 window, flattened in the engine's layout, with a one-cycle-per-window valid/ready handshake whose accepted beats drive `start_conv`. Supports stride 1 and stride 2 with no padding ("valid" convolution).

## Interface
Parameters:
- MAX_WIDTH, 224: maximum row length held by each line buffer.
- COL_W, $clog2(MAX_WIDTH+1): width of column-size/counter fields.
- ROW_W, 16: width of row-size/counter fields.

Ports:
- clock  in  1  single clock, all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; latches cfg_* and begins a frame (IDLE only).
- cfg_width  in  COL_W  image width W, legal 3..MAX_WIDTH.
- cfg_height  in  ROW_W  image height H, legal ≥3.
- cfg_stride2  in  1  0 = stride 1, 1 = stride 2.
- pixel_in  in  8  input pixel, raster order.
- pixel_valid  in  1  pixel_in is valid.
- pixel_ready  out  1  block accepts pixel this cycle.
- window_out  out  8 × [8:0]  unpacked window; [0]=top-left, [2]=top-right, [8]=bottom-right.
- window_valid  out  1  window_out holds a valid window.
- window_ready  in  1  consumer accepts window (drives engine start_conv = valid & ready).
- window_row  out  ROW_W  output-map row of current window.
- window_col  out  COL_W  output-map column of current window.
- busy  out  1  high in RUN or DRAIN.
- frame_done  out  1  one-cycle pulse when last window of frame is accepted.
- cfg_error  out  1  one-cycle pulse when start is rejected for illegal config.

## Operation
- States: IDLE → RUN → DRAIN → IDLE.
- IDLE: pixel_ready=0. On start with legal config: latch cfg, clear row/col counters r=c=0, go RUN. Illegal (W<3, W>MAX_WIDTH, H<3): stay IDLE, pulse cfg_error next cycle.
- start outside IDLE is ignored.
- RUN: pixel_ready = !window_valid | window_ready. Pixel accepted when pixel_valid & pixel_ready.
- On acceptance at (r,c): new column = {lb_a[c], lb_b[c], pixel_in} (top, mid, bottom); lb_a[c] ← lb_b[c]; lb_b[c] ← pixel_in; window shifts left one column, new column enters at right (positions 2,5,8).
- Window emitted (window_valid set next cycle) iff r≥2, c≥2 and, when cfg_stride2, (r−2) and (c−2) both even.
- window_row = (r−2)>>cfg_stride2; window_col = (c−2)>>cfg_stride2.
- c wraps to 0 at W−1 and r increments; stale columns from the previous row never emitted since c≥2 is required.
- After accepting pixel (H−1,W−1): go DRAIN. DRAIN: pixel_ready=0; when no window pending (or it is accepted this cycle), pulse frame_done, go IDLE. If final pixel produces no window (stride-2, odd parity), frame_done pulses the cycle after DRAIN entry.
- Output count: stride 1 (W−2)(H−2); stride 2 ⌊(W−1)/2⌋·⌊(H−1)/2⌋.

## Timing
- Reset values: pixel_ready=0, window_valid=0, window_out all 0, window_row=0, window_col=0, busy=0, frame_done=0, cfg_error=0; state IDLE. Line-buffer contents are not reset.
- Latency: pixel accept at cycle N → window_valid at N+1.
- window_out/row/col stable while window_valid & !window_ready; new pixel accepted in the same cycle a window is accepted (full throughput, 1 pixel/cycle).
- busy asserted the cycle after accepted start.
- Reset mid-frame: next cycle in IDLE, all outputs at reset values, pending window dropped, no frame_done.

## Structure
- Shared package `conv_pkg`: WIN_SIZE=9, PIX_W=8, typedef `pix_t` (logic [7:0]), `win_t` (pix_t [8:0]), state enum `wg_state_e`.
- One sub-module `line_buffer` (MAX_WIDTH×8 array, combinational read, sync write, same address); instantiated twice (lb_a, lb_b).

## Test plan
- 4×4, stride 1, pixel=4r+c, window_ready=1 → 4 windows; first {0,1,2,4,5,6,8,9,10} at (0,0); last {5,6,7,9,10,11,13,14,15} at (1,1); frame_done once.
- 5×5, stride 2, pixel=5r+c → 4 windows at (0,0),(0,1),(1,0),(1,1); window (1,1) = {12,13,14,17,18,19,22,23,24}.
- 4×4 stride 1 with window_ready low 5 cycles on first window → pixel_ready low, window_out constant, no pixel lost; same 4 windows.
- start with cfg_width=2 → cfg_error pulse, busy stays 0, pixel_ready stays 0.
- reset asserted after 7 pixels of a 4×4 frame → all outputs reset next cycle; new 4×4 frame then yields correct 4 windows.
- Two back-to-back 3×3 frames (start one cycle after frame_done) → exactly one window each, correct contents.
